priority_irq_encoder: RTL and testbench

PRIORITY_IRQ_ENCODER -- requirements
Module: priority_irq_encoder

---
 rtl/priority_irq_pkg.sv | 15 +
 rtl/priority_irq_encoder_prio_find.sv | 24 ++
 rtl/priority_irq_encoder.sv | 118 +++++++++++
 tb/tb_priority_irq_encoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_irq_pkg.sv
// Shared definitions for the priority interrupt encoder: default sizing and
// the FSM state encoding used by the top level.
package priority_irq_pkg;

  // Default number of request lines and the matching index width.
  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned W_DEFAULT = $clog2(N_DEFAULT);

  // Two-state presentation FSM: waiting for a request, or holding one.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/priority_irq_encoder_prio_find.sv
// Combinational highest-index finder: reports the position of the most
// significant set bit of req and whether any bit is set at all.
module prio_find #(
  parameter int N = priority_irq_pkg::N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] index,
  output logic         found
);

  // Ascending scan so the last hit (highest index) is the one that sticks.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        index = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_irq_encoder.sv
// Priority interrupt encoder. Active-low request lines are edge detected
// (high-to-low) into a pending register, filtered by a mask, and the highest
// unmasked pending index is presented to a consumer, held until acknowledged.
module priority_irq_encoder
  import priority_irq_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [N-1:0] iData,
  input  logic         iEI,
  input  logic         iMaskWe,
  input  logic [N-1:0] iMask,
  input  logic         iAck,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic         oEO
);

  state_e         state_q, state_d;
  logic [N-1:0]   prev_q, prev_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           eo_q, eo_d;

  logic [N-1:0]   fall;
  logic [N-1:0]   sel_req;
  logic [N-1:0]   ack_clr;
  logic [W-1:0]   sel_index;
  logic           sel_found;
  logic           next_sel_any;

  // Selection works on the registered pending/mask so a new edge takes one
  // extra cycle to reach the output.
  assign sel_req = pending_q & ~mask_q;

  prio_find #(
    .N (N),
    .W (W)
  ) u_prio_find (
    .req   (sel_req),
    .index (sel_index),
    .found (sel_found)
  );

  // Request capture: falling edges set pending, an ack clears only the
  // presented line, and a same-edge fall on that line keeps it set.
  always_comb begin
    fall    = prev_q & ~iData;
    prev_d  = iData;
    mask_d  = iMaskWe ? iMask : mask_q;
    ack_clr = '0;
    if (state_q == ST_PRESENT && iAck) begin
      ack_clr = {{(N-1){1'b0}}, 1'b1} << data_q;
    end
    pending_d    = (pending_q & ~ack_clr) | fall;
    next_sel_any = |(pending_d & ~mask_d);
  end

  // Presentation FSM plus the registered idle/enable status output.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (!iEI && sel_found) begin
          state_d = ST_PRESENT;
          data_d  = sel_index;
          valid_d = 1'b1;
        end
      end
      ST_PRESENT: begin
        // Index stays frozen regardless of enable, mask or new edges.
        if (iAck) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // Enabled and idle with nothing left to offer after this edge.
    eo_d = !((state_d == ST_IDLE) && !iEI && !next_sel_any);
  end

  // State registers; reset is asynchronous and overrides any presentation.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      eo_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      eo_q      <= eo_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oEO    = eo_q;

endmodule

// File: tb/tb_priority_irq_encoder.sv
// Testbench for priority_irq_encoder (N=8): a behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_priority_irq_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         iClk;
  logic         iRst;
  logic [N-1:0] iData;
  logic         iEI;
  logic         iMaskWe;
  logic [N-1:0] iMask;
  logic         iAck;
  logic [W-1:0] oData;
  logic         oValid;
  logic         oEO;

  int tests_run = 0;
  int tests_failed = 0;

  priority_irq_encoder #(.N(N), .W(W)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iData   (iData),
    .iEI     (iEI),
    .iMaskWe (iMaskWe),
    .iMask   (iMask),
    .iAck    (iAck),
    .oData   (oData),
    .oValid  (oValid),
    .oEO     (oEO)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Behavioural model: per-line bits, a "presenting" flag and the held index.
  typedef struct {
    bit prev [N];
    bit pend [N];
    bit msk  [N];
    bit pres;
    int idx;
    bit eo;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    for (int i = 0; i < N; i++) begin
      r.prev[i] = 1'b1;
      r.pend[i] = 1'b0;
      r.msk[i]  = 1'b0;
    end
    r.pres = 1'b0;
    r.idx  = 0;
    r.eo   = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [N-1:0] d, logic ei,
                                    logic we, logic [N-1:0] mk, logic ack);
    mdl_t n;
    int   best;
    bit   any_left;
    n = s;
    // Highest unmasked pending line, as seen before this edge.
    best = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (best < 0 && s.pend[i] && !s.msk[i]) best = i;
    end
    if (s.pres && ack) n.pend[s.idx] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s.prev[i] && !d[i]) n.pend[i] = 1'b1;
      n.prev[i] = d[i];
      if (we) n.msk[i] = mk[i];
    end
    if (!s.pres) begin
      if (!ei && best >= 0) begin
        n.pres = 1'b1;
        n.idx  = best;
      end
    end else if (ack) begin
      n.pres = 1'b0;
    end
    any_left = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (n.pend[i] && !n.msk[i]) any_left = 1'b1;
    end
    n.eo = !(!n.pres && !ei && !any_left);
    return n;
  endfunction

  always @(posedge iClk or posedge iRst) begin
    if (iRst) m <= mdl_reset();
    else      m <= mdl_step(m, iData, iEI, iMaskWe, iMask, iAck);
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge iClk) begin
    check("model_valid", int'(oValid), int'(m.pres));
    check("model_eo", int'(oEO), int'(m.eo));
    if (m.pres) check("model_data", int'(oData), m.idx);
  end

  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic ack_once();
    iAck = 1'b1;
    step(1);
    iAck = 1'b0;
  endtask

  initial begin
    iRst    = 1'b1;
    iData   = 8'h5A;
    iEI     = 1'b0;
    iMaskWe = 1'b1;
    iMask   = 8'hFF;
    iAck    = 1'b1;
    step(2);
    $display("[TB] reset held with arbitrary inputs");
    check("rst_valid", int'(oValid), 0);
    check("rst_data", int'(oData), 0);
    check("rst_eo", int'(oEO), 1);
    iData = 8'hFF; iMaskWe = 1'b0; iMask = 8'h00; iAck = 1'b0;
    iRst  = 1'b0;
    step(3);
    $display("[TB] reset released, lines idle");
    check("post_rst_valid", int'(oValid), 0);
    check("post_rst_eo", int'(oEO), 0);

    // Single request on line 0.
    iData = 8'hFE;
    step(1);
    check("single_latency", int'(oValid), 0);
    step(1);
    $display("[TB] single request line 0: valid=%0d data=%0d", oValid, oData);
    check("single_valid", int'(oValid), 1);
    check("single_data", int'(oData), 0);
    ack_once();
    check("single_ack_valid", int'(oValid), 0);
    check("single_ack_eo", int'(oEO), 0);
    iData = 8'hFF; step(1);

    // Lines 6 and 3 together: 6 first, gap, then 3.
    iData = 8'hB7;
    step(2);
    $display("[TB] priority 6+3: data=%0d", oData);
    check("prio_first", int'(oData), 6);
    ack_once();
    check("prio_gap", int'(oValid), 0);
    step(1);
    check("prio_second_valid", int'(oValid), 1);
    check("prio_second", int'(oData), 3);
    ack_once();
    check("prio_done_eo", int'(oEO), 0);
    iData = 8'hFF; step(1);

    // Mask line 6, so 3 wins; unmask and 6 follows.
    iMaskWe = 1'b1; iMask = 8'h40; step(1); iMaskWe = 1'b0;
    iData = 8'hB7;
    step(2);
    $display("[TB] masked 6: data=%0d", oData);
    check("mask_sel", int'(oData), 3);
    iMaskWe = 1'b1; iMask = 8'h00; step(1); iMaskWe = 1'b0;
    check("mask_hold", int'(oData), 3);
    ack_once();
    step(1);
    check("unmask_sel", int'(oData), 6);
    ack_once();
    iData = 8'hFF; step(1);

    // Disabled: line 5 accumulates; enable grants; higher edge cannot preempt.
    iEI = 1'b1; iData = 8'hDF;
    step(2);
    $display("[TB] disabled with line 5 pending: valid=%0d eo=%0d", oValid, oEO);
    check("dis_valid", int'(oValid), 0);
    check("dis_eo", int'(oEO), 1);
    iEI = 1'b0;
    step(1);
    check("en_data", int'(oData), 5);
    iData = 8'h5F;
    step(2);
    check("stable_valid", int'(oValid), 1);
    check("stable_data", int'(oData), 5);
    ack_once();
    step(1);
    $display("[TB] after ack of 5: data=%0d", oData);
    check("after_stable", int'(oData), 7);
    ack_once();
    iData = 8'hFF; step(1);

    // Collision: ack of 2 on the same edge as a new fall on line 2.
    iData = 8'hFB;
    step(2);
    check("coll_first", int'(oData), 2);
    iData = 8'hFF; step(1);
    iData = 8'hFB; iAck = 1'b1; step(1); iAck = 1'b0;
    check("coll_gap", int'(oValid), 0);
    step(1);
    $display("[TB] collision re-present: valid=%0d data=%0d", oValid, oData);
    check("coll_again_valid", int'(oValid), 1);
    check("coll_again", int'(oData), 2);

    // Reset while presenting: outputs drop immediately, pending cleared.
    #2 iRst = 1'b1;
    #1;
    $display("[TB] reset mid-present: valid=%0d eo=%0d", oValid, oEO);
    check("midrst_valid", int'(oValid), 0);
    check("midrst_eo", int'(oEO), 1);
    check("midrst_data", int'(oData), 0);
    iData = 8'hFF;
    step(1);
    iRst = 1'b0;
    step(3);
    check("midrst_cleared", int'(oValid), 0);

    // Line held low across reset release counts as a fresh request.
    iRst = 1'b1; iData = 8'hF7;
    step(1);
    iRst = 1'b0;
    step(2);
    $display("[TB] low at release line 3: valid=%0d data=%0d", oValid, oData);
    check("rel_valid", int'(oValid), 1);
    check("rel_data", int'(oData), 3);
    ack_once();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
